// File: rtl/usb_pkg.sv
// Shared USB proxy definitions: PID bytes, decoder done state, injector FSM
// states and HID boot-keyboard report layout.
package usb_pkg;

  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  localparam int USB_DONE_STATE = 4;

  localparam int RPT_MOD_LSB = 0;
  localparam int RPT_KEY_LSB = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM_PRESS,
    ST_WIN_PRESS,
    ST_ARM_REL,
    ST_WIN_REL,
    ST_GAP
  } inj_state_e;

  // key[15:8] is the modifier byte, key[7:0] the keycode
  function automatic logic [63:0] press_report(input logic [15:0] key);
    logic [63:0] r;
    r = '0;
    r[RPT_MOD_LSB +: 8] = key[15:8];
    r[RPT_KEY_LSB +: 8] = key[7:0];
    return r;
  endfunction

  function automatic logic is_data_pid(input logic [7:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous keystroke FIFO; the head entry is presented through a
// registered read port.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  head_q;

  always_ff @(posedge clk) begin
    if (push_i) mem[wr_ptr_q] <= push_data_i;
  end

  // Head lags a pointer change by one cycle; the injector never consumes it
  // within two cycles of a push-to-empty or a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      head_q <= mem[rd_ptr_q];
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/keystroke_injector.sv
// Replaces IN-transaction DATA payloads with queued keyboard press/release
// reports, one poll at a time, while the keyboard is owned.
module keystroke_injector import usb_pkg::*; #(
  parameter int DEPTH      = 8,
  parameter int GAP_POLLS  = 1,
  parameter int DONE_STATE = USB_DONE_STATE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               usb_state,
  input  logic [7:0]               pid,
  input  logic                     enable,
  input  logic                     push_valid,
  input  logic [15:0]              push_data,
  output logic                     push_ready,
  output logic                     sub_active,
  output logic [63:0]              sub_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     overflow
);

  localparam int GW = (GAP_POLLS > 0) ? $clog2(GAP_POLLS + 1) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_POLLS);

  inj_state_e    state_q, state_d;
  logic          sub_active_q, sub_active_d;
  logic [63:0]   sub_data_q, sub_data_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          overflow_q, overflow_d;

  logic        pkt_done, is_in, is_data;
  logic        fifo_full, fifo_empty, pop;
  logic [15:0] head;

  assign pkt_done = (usb_state == 3'(DONE_STATE));
  assign is_in    = (pid == PID_IN);
  assign is_data  = is_data_pid(pid);

  key_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_valid && !fifo_full),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    sub_active_d = sub_active_q;
    sub_data_d   = sub_data_q;
    gap_d        = gap_q;
    pop          = 1'b0;
    overflow_d   = overflow_q | (push_valid & fifo_full);
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) state_d = ST_ARM_PRESS;
      end
      ST_ARM_PRESS: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (pkt_done && is_in) begin
          state_d      = ST_WIN_PRESS;
          sub_active_d = 1'b1;
          sub_data_d   = press_report(head);
        end
      end
      ST_WIN_PRESS: begin
        if (pkt_done) begin
          sub_active_d = 1'b0;
          if (is_data) begin
            pop     = 1'b1;
            state_d = ST_ARM_REL;
          end else begin
            state_d = ST_ARM_PRESS;
          end
        end
      end
      // Release path ignores enable so a key is never left held down.
      ST_ARM_REL: begin
        if (pkt_done && is_in) begin
          state_d      = ST_WIN_REL;
          sub_active_d = 1'b1;
          sub_data_d   = '0;
        end
      end
      ST_WIN_REL: begin
        if (pkt_done) begin
          sub_active_d = 1'b0;
          if (is_data) begin
            state_d = ST_GAP;
            gap_d   = GAP_INIT;
          end else begin
            state_d = ST_ARM_REL;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = (enable && !fifo_empty) ? ST_ARM_PRESS : ST_IDLE;
        end else if (pkt_done && is_in) begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sub_active_q <= 1'b0;
      sub_data_q   <= '0;
      gap_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sub_active_q <= sub_active_d;
      sub_data_q   <= sub_data_d;
      gap_q        <= gap_d;
      overflow_q   <= overflow_d;
    end
  end

  assign push_ready = !fifo_full;
  assign sub_active = sub_active_q;
  assign sub_data   = sub_data_q;
  assign busy       = (state_q != ST_IDLE);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_keystroke_injector.sv
// Scenario bench for keystroke_injector: expected keys are queued when pushed
// and compared against each press window the DUT opens.
module tb_keystroke_injector;
  import usb_pkg::*;

  localparam int DEPTH = 8;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  usb_state = 3'd0;
  logic [7:0]  pid = 8'h00;
  logic        enable = 1'b0;
  logic        push_valid = 1'b0;
  logic [15:0] push_data = 16'h0;
  logic        push_ready, sub_active, busy, overflow;
  logic [63:0] sub_data;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  keystroke_injector #(.DEPTH(DEPTH), .GAP_POLLS(GAP), .DONE_STATE(USB_DONE_STATE)) dut (
    .clk        (clk),
    .rst        (rst),
    .usb_state  (usb_state),
    .pid        (pid),
    .enable     (enable),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .sub_active (sub_active),
    .sub_data   (sub_data),
    .fifo_count (fifo_count),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] press_of(input logic [15:0] k);
    return {40'h0, k[7:0], 8'h00, k[15:8]};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_key(input logic [15:0] k);
    @(posedge clk); #1;
    push_valid = 1'b1;
    push_data  = k;
    if (exp_q.size() < DEPTH) exp_q.push_back(k);
    @(posedge clk); #1;
    push_valid = 1'b0;
    $display("push key=%h model_depth=%0d", k, exp_q.size());
  endtask

  task automatic send_pkt(input logic [7:0] p);
    @(posedge clk); #1;
    pid       = p;
    usb_state = 3'(USB_DONE_STATE);
    @(posedge clk); #1;
    usb_state = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    $display("pkt pid=%h sub_active=%b sub_data=%h count=%0d", p, sub_active, sub_data, fifo_count);
  endtask

  task automatic test_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    checks++; if (sub_active !== 1'b0) begin errors++; $display("FAIL rst_sub_active: got %b want 0", sub_active); end
    checks++; if (sub_data !== 64'h0) begin errors++; $display("FAIL rst_sub_data: got %h want 0", sub_data); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_busy_ovf: got %b%b want 00", busy, overflow); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL rst_push_ready: got %b want 1", push_ready); end
  endtask

  task automatic test_basic();
    enable = 1'b1;
    push_key(16'h0204);
    idle(3);
    checks++; if (busy !== 1'b1 || fifo_count !== 4'd1) begin errors++; $display("FAIL basic_armed: busy=%b count=%0d want 1/1", busy, fifo_count); end
    send_pkt(PID_IN);
    checks++; if (sub_active !== 1'b1 || sub_data !== 64'h0000_0000_0004_0002) begin errors++; $display("FAIL basic_press: sa=%b data=%h want 1/%h", sub_active, sub_data, 64'h0000_0000_0004_0002); end
    send_pkt(PID_DATA0);
    void'(exp_q.pop_front());
    checks++; if (sub_active !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL basic_pop: sa=%b count=%0d want 0/0", sub_active, fifo_count); end
    send_pkt(PID_IN);
    checks++; if (sub_active !== 1'b1 || sub_data !== 64'h0) begin errors++; $display("FAIL basic_release: sa=%b data=%h want 1/0", sub_active, sub_data); end
    send_pkt(PID_DATA1);
    checks++; if (sub_active !== 1'b0) begin errors++; $display("FAIL basic_rel_close: sa=%b want 0", sub_active); end
    for (int g = 0; g < GAP; g++) begin
      send_pkt(PID_IN);
      checks++; if (sub_active !== 1'b0) begin errors++; $display("FAIL basic_gap%0d: sa=%b want 0", g, sub_active); end
      send_pkt(PID_DATA0);
    end
    idle(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_nak();
    push_key(16'h0005);
    idle(3);
    send_pkt(PID_IN);
    checks++; if (sub_active !== 1'b1 || sub_data !== press_of(exp_q[0])) begin errors++; $display("FAIL nak_press1: sa=%b data=%h want 1/%h", sub_active, sub_data, press_of(exp_q[0])); end
    send_pkt(PID_NAK);
    checks++; if (sub_active !== 1'b0 || fifo_count !== 4'd1) begin errors++; $display("FAIL nak_kept: sa=%b count=%0d want 0/1", sub_active, fifo_count); end
    send_pkt(PID_IN);
    checks++; if (sub_active !== 1'b1 || sub_data !== press_of(exp_q[0])) begin errors++; $display("FAIL nak_retry: sa=%b data=%h want 1/%h", sub_active, sub_data, press_of(exp_q[0])); end
    send_pkt(PID_DATA0);
    void'(exp_q.pop_front());
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL nak_pop: count=%0d want 0", fifo_count); end
    send_pkt(PID_OUT);
    send_pkt(PID_DATA0);
    checks++; if (sub_active !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL nak_out_ignored: sa=%b busy=%b want 0/1", sub_active, busy); end
    send_pkt(PID_IN);
    checks++; if (sub_active !== 1'b1 || sub_data !== 64'h0) begin errors++; $display("FAIL nak_release: sa=%b data=%h want 1/0", sub_active, sub_data); end
    send_pkt(PID_DATA0);
    for (int g = 0; g < GAP; g++) begin
      send_pkt(PID_IN);
      send_pkt(PID_DATA0);
    end
    idle(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nak_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_enable_drop();
    push_key(16'h0111);
    push_key(16'h0222);
    idle(3);
    send_pkt(PID_IN);
    checks++; if (sub_active !== 1'b1 || sub_data !== press_of(exp_q[0])) begin errors++; $display("FAIL en_press: sa=%b data=%h want 1/%h", sub_active, sub_data, press_of(exp_q[0])); end
    enable = 1'b0;
    send_pkt(PID_DATA0);
    void'(exp_q.pop_front());
    send_pkt(PID_IN);
    checks++; if (sub_active !== 1'b1 || sub_data !== 64'h0) begin errors++; $display("FAIL en_release: sa=%b data=%h want 1/0", sub_active, sub_data); end
    send_pkt(PID_DATA0);
    for (int g = 0; g < GAP; g++) begin
      send_pkt(PID_IN);
      send_pkt(PID_DATA0);
    end
    idle(3);
    send_pkt(PID_IN);
    checks++; if (sub_active !== 1'b0 || busy !== 1'b0 || fifo_count !== 4'd1) begin errors++; $display("FAIL en_hold: sa=%b busy=%b count=%0d want 0/0/1", sub_active, busy, fifo_count); end
    enable = 1'b1;
    idle(3);
    send_pkt(PID_IN);
    checks++; if (sub_active !== 1'b1 || sub_data !== press_of(exp_q[0])) begin errors++; $display("FAIL en_resume: sa=%b data=%h want 1/%h", sub_active, sub_data, press_of(exp_q[0])); end
    send_pkt(PID_DATA0);
    void'(exp_q.pop_front());
    send_pkt(PID_IN);
    send_pkt(PID_DATA0);
    for (int g = 0; g < GAP; g++) begin
      send_pkt(PID_IN);
      send_pkt(PID_DATA0);
    end
    idle(2);
    checks++; if (busy !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL en_drained: busy=%b count=%0d want 0/0", busy, fifo_count); end
  endtask

  task automatic test_gap_pattern();
    enable = 1'b0;
    push_key(16'h0A11);
    push_key(16'h0B22);
    push_key(16'h0C33);
    enable = 1'b1;
    idle(3);
    for (int k = 0; k < 3; k++) begin
      send_pkt(PID_IN);
      checks++; if (sub_active !== 1'b1 || sub_data !== press_of(exp_q[0])) begin errors++; $display("FAIL gap_press%0d: sa=%b data=%h want 1/%h", k, sub_active, sub_data, press_of(exp_q[0])); end
      send_pkt(PID_DATA0);
      void'(exp_q.pop_front());
      send_pkt(PID_IN);
      checks++; if (sub_active !== 1'b1 || sub_data !== 64'h0) begin errors++; $display("FAIL gap_rel%0d: sa=%b data=%h want 1/0", k, sub_active, sub_data); end
      send_pkt(PID_DATA1);
      for (int g = 0; g < GAP; g++) begin
        send_pkt(PID_IN);
        checks++; if (sub_active !== 1'b0) begin errors++; $display("FAIL gap_pass%0d_%0d: sa=%b want 0", k, g, sub_active); end
        send_pkt(PID_DATA0);
      end
    end
    idle(2);
    checks++; if (busy !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL gap_end: busy=%b count=%0d want 0/0", busy, fifo_count); end
  endtask

  task automatic test_overflow();
    enable = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push_key(16'h0100 + 16'(i));
    checks++; if (fifo_count !== 4'(DEPTH)) begin errors++; $display("FAIL ovf_count: got %0d want %0d", fifo_count, DEPTH); end
    checks++; if (push_ready !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_flags: ready=%b ovf=%b want 0/1", push_ready, overflow); end
  endtask

  task automatic test_rst_mid();
    enable = 1'b1;
    idle(3);
    send_pkt(PID_IN);
    checks++; if (sub_active !== 1'b1 || sub_data !== press_of(exp_q[0])) begin errors++; $display("FAIL rstmid_press: sa=%b data=%h want 1/%h", sub_active, sub_data, press_of(exp_q[0])); end
    send_pkt(PID_DATA0);
    void'(exp_q.pop_front());
    send_pkt(PID_IN);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    checks++; if (sub_active !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL rstmid_clear: sa=%b count=%0d want 0/0", sub_active, fifo_count); end
    checks++; if (busy !== 1'b0 || overflow !== 1'b0 || push_ready !== 1'b1) begin errors++; $display("FAIL rstmid_flags: busy=%b ovf=%b ready=%b want 0/0/1", busy, overflow, push_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nak();
    test_enable_drop();
    test_gap_pattern();
    test_overflow();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
